// File: rtl/timer_pwm_sequencer_if.sv
// Timer slave write port as seen by the PWM sequencer.
// The sequencer is the master; the timer register block is the slave.
interface timer_pwm_sequencer_if;
  logic        w_enable;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        err;

  modport master (
    output w_enable,
    output w_addr,
    output w_data,
    input  err
  );

  modport slave (
    input  w_enable,
    input  w_addr,
    input  w_data,
    output err
  );
endinterface

// File: rtl/timer_pwm_sequencer.sv
// PWM duty-cycle sequencer: on every timer overflow it writes the next table entry into
// the timer's pulse registers (addr 4 = {ch2,ch1}, addr 5 = {ch4,ch3}), then loops or stops.
// Optional macro TIM_SEQ_CLR_OVF_EN adds a third write per entry (addr 2 <- 0) that clears
// the timer's overflow status.
module timer_pwm_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_CfgWe,
  input  logic [IDX_W-1:0]     i_CfgAddr,
  input  logic [31:0]          i_CfgData,
  input  logic                 i_Start,
  input  logic                 i_Stop,
  input  logic [IDX_W:0]       i_Length,
  input  logic                 i_Loop,
  input  logic                 i_TimerOverflow,
  timer_pwm_sequencer_if.master bus,
  output logic                 o_Busy,
  output logic [IDX_W-1:0]     o_Index,
  output logic                 o_Done,
  output logic                 o_ErrFlag,
  output logic                 o_Overrun
);

  localparam logic [IDX_W:0] LenMax = (IDX_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StWrLo,
    StWrHi,
`ifdef TIM_SEQ_CLR_OVF_EN
    StWrClr,
`endif
    StWaitOvf
  } state_e;

  state_e           state_q;
  logic [31:0]      table_q [DEPTH];
  logic [IDX_W-1:0] index_q;
  logic [IDX_W-1:0] last_q;
  logic             loop_q;
  logic [15:0]      hi_q;
  logic             ovf_q;
  logic             ovf_prev_q;
  logic             pending_q;
  logic             wen_prev_q;
  logic             w_enable_q;
  logic [31:0]      w_addr_q;
  logic [31:0]      w_data_q;
  logic             err_flag_q;
  logic             overrun_q;

  logic             ovf_edge;
  logic             trigger;
  logic             at_last;
  logic [IDX_W-1:0] next_index;
  logic             start_ok;
  logic             in_write;

  // Derived strobes: overflow edge, advance condition and start qualification.
  always_comb begin
    ovf_edge   = ovf_q & ~ovf_prev_q;
    trigger    = (state_q == StWaitOvf) && (ovf_edge || pending_q);
    at_last    = (index_q == last_q);
    next_index = at_last ? '0 : index_q + 1'b1;
    start_ok   = i_Start && (i_Length != '0) && (i_Length <= LenMax);
    in_write   = (state_q != StIdle) && (state_q != StWaitOvf);
    // Combinational so it lands in the cycle the terminating edge is consumed.
    o_Done     = trigger && at_last && !loop_q && !i_Stop;
  end

  // Duty table; no reset, software loads it before starting.
  always_ff @(posedge i_Clk) begin
    if (i_CfgWe) begin
      table_q[i_CfgAddr] <= i_CfgData;
    end
  end

  // Overflow level history for edge detection and write history for error attribution.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      ovf_q      <= 1'b0;
      ovf_prev_q <= 1'b0;
      wen_prev_q <= 1'b0;
    end else begin
      ovf_q      <= i_TimerOverflow;
      ovf_prev_q <= ovf_q;
      wen_prev_q <= w_enable_q;
    end
  end

  // Sequencer FSM with registered bus outputs and sticky status flags.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= StIdle;
      index_q    <= '0;
      last_q     <= '0;
      loop_q     <= 1'b0;
      hi_q       <= '0;
      pending_q  <= 1'b0;
      w_enable_q <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      err_flag_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      w_enable_q <= 1'b0;
      if (wen_prev_q && bus.err) begin
        err_flag_q <= 1'b1;
      end
      // Edges during the write burst are remembered; a second one is lost.
      if (ovf_edge && in_write) begin
        if (pending_q) begin
          overrun_q <= 1'b1;
        end
        pending_q <= 1'b1;
      end
      if (i_Stop) begin
        state_q   <= StIdle;
        pending_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_ok) begin
              state_q    <= StWrLo;
              index_q    <= '0;
              last_q     <= i_Length[IDX_W-1:0] - 1'b1;
              loop_q     <= i_Loop;
              pending_q  <= 1'b0;
              err_flag_q <= 1'b0;
              overrun_q  <= 1'b0;
              w_enable_q <= 1'b1;
              w_addr_q   <= 32'd4;
              w_data_q   <= {16'h0, table_q[0][15:0]};
              hi_q       <= table_q[0][31:16];
            end
          end
          StWrLo: begin
            state_q    <= StWrHi;
            w_enable_q <= 1'b1;
            w_addr_q   <= 32'd5;
            w_data_q   <= {16'h0, hi_q};
          end
          StWrHi: begin
`ifdef TIM_SEQ_CLR_OVF_EN
            state_q    <= StWrClr;
            w_enable_q <= 1'b1;
            w_addr_q   <= 32'd2;
            w_data_q   <= 32'h0;
`else
            state_q    <= StWaitOvf;
`endif
          end
`ifdef TIM_SEQ_CLR_OVF_EN
          StWrClr: begin
            state_q <= StWaitOvf;
          end
`endif
          StWaitOvf: begin
            if (trigger) begin
              // Pending and a fresh edge together: consume one, keep the other.
              pending_q <= ovf_edge & pending_q;
              if (at_last && !loop_q) begin
                state_q   <= StIdle;
                pending_q <= 1'b0;
              end else begin
                state_q    <= StWrLo;
                index_q    <= next_index;
                w_enable_q <= 1'b1;
                w_addr_q   <= 32'd4;
                w_data_q   <= {16'h0, table_q[next_index][15:0]};
                hi_q       <= table_q[next_index][31:16];
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.w_enable = w_enable_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_data   = w_data_q;
  assign o_Busy       = (state_q != StIdle);
  assign o_Index      = index_q;
  assign o_ErrFlag    = err_flag_q;
  assign o_Overrun    = overrun_q;

endmodule

// File: tb/tb_timer_pwm_sequencer.sv
// Directed bench for timer_pwm_sequencer; inputs driven and outputs sampled on the negedge.
module tb_timer_pwm_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [31:0] cfg_data;
  logic       start;
  logic       stop;
  logic [4:0] length;
  logic       loop_en;
  logic       ovf;
  logic       busy;
  logic [3:0] index;
  logic       done;
  logic       err_flag;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [15:0] exp_lo [3] = '{16'h0001, 16'h0002, 16'h0006};
  logic [15:0] exp_hi [3] = '{16'h0003, 16'h0004, 16'h0005};

  timer_pwm_sequencer_if bus_if ();

  timer_pwm_sequencer #(
    .DEPTH(16),
    .IDX_W(4)
  ) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_CfgWe        (cfg_we),
    .i_CfgAddr      (cfg_addr),
    .i_CfgData      (cfg_data),
    .i_Start        (start),
    .i_Stop         (stop),
    .i_Length       (length),
    .i_Loop         (loop_en),
    .i_TimerOverflow(ovf),
    .bus            (bus_if),
    .o_Busy         (busy),
    .o_Index        (index),
    .o_Done         (done),
    .o_ErrFlag      (err_flag),
    .o_Overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  // At the negedge of a WR_LO cycle; returns at the negedge of the first WAIT_OVF cycle.
  task automatic run_entry(input int idx);
    if (bus_if.w_enable !== 1'b1 || bus_if.w_addr !== 32'd4 || bus_if.w_data !== {16'h0, exp_lo[idx]}
        || index !== 4'(idx) || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_lo[%0d]: got en=%b addr=%0d data=%h idx=%0d busy=%b, want en=1 addr=4 data=%h idx=%0d busy=1",
               idx, bus_if.w_enable, bus_if.w_addr, bus_if.w_data, index, busy, exp_lo[idx], idx);
    end
    checks++;
    step();
    if (bus_if.w_enable !== 1'b1 || bus_if.w_addr !== 32'd5 || bus_if.w_data !== {16'h0, exp_hi[idx]}) begin
      errors++;
      $display("FAIL wr_hi[%0d]: got en=%b addr=%0d data=%h, want en=1 addr=5 data=%h",
               idx, bus_if.w_enable, bus_if.w_addr, bus_if.w_data, exp_hi[idx]);
    end
    checks++;
    step();
`ifdef TIM_SEQ_CLR_OVF_EN
    if (bus_if.w_enable !== 1'b1 || bus_if.w_addr !== 32'd2 || bus_if.w_data !== 32'h0) begin
      errors++;
      $display("FAIL wr_clr[%0d]: got en=%b addr=%0d data=%h, want en=1 addr=2 data=0",
               idx, bus_if.w_enable, bus_if.w_addr, bus_if.w_data);
    end
    checks++;
    step();
`endif
    if (bus_if.w_enable !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_ovf[%0d]: got en=%b busy=%b, want en=0 busy=1", idx, bus_if.w_enable, busy);
    end
    checks++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0; stop = 1'b0;
    length = '0; loop_en = 1'b0; ovf = 1'b0; bus_if.err = 1'b0;
    step(); step();
    if (bus_if.w_enable !== 1'b0 || bus_if.w_addr !== 32'h0 || bus_if.w_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got en=%b addr=%h data=%h, want all 0", bus_if.w_enable, bus_if.w_addr, bus_if.w_data);
    end
    checks++;
    if (busy !== 1'b0 || index !== 4'd0 || done !== 1'b0 || err_flag !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b idx=%0d done=%b err=%b ovr=%b, want all 0",
               busy, index, done, err_flag, overrun);
    end
    checks++;
    rst = 1'b0;
    step();
  endtask

  task automatic load_table();
    for (int i = 0; i < 3; i++) begin
      cfg_we = 1'b1; cfg_addr = 4'(i); cfg_data = {exp_hi[i], exp_lo[i]};
      step();
    end
    cfg_we = 1'b0;
    step();
  endtask

  task automatic test_single_run();
    int d0;
    d0 = done_cnt;
    length = 5'd3; loop_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 0; e < 3; e++) begin
      if (e > 0) step();
      else run_entry(0);
      if (e > 0) run_entry(e);
      ovf = 1'b1;
      step();
      ovf = 1'b0;
      if (done !== (e == 2) || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_done[%0d]: got done=%b busy=%b, want done=%b busy=1", e, done, busy, e == 2);
      end
      checks++;
    end
    step();
    if (done !== 1'b0 || busy !== 1'b0 || bus_if.w_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_end: got done=%b busy=%b en=%b, want 0 0 0", done, busy, bus_if.w_enable);
    end
    checks++;
`ifdef TIM_SEQ_CLR_OVF_EN
    if (bus_if.w_addr !== 32'd2 || bus_if.w_data !== 32'h0) begin
`else
    if (bus_if.w_addr !== 32'd5 || bus_if.w_data !== 32'h5) begin
`endif
      errors++;
      $display("FAIL single_hold: got addr=%0d data=%h, want last write held", bus_if.w_addr, bus_if.w_data);
    end
    checks++;
    step(); step();
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL single_done_count: got %0d pulses, want 1", done_cnt - d0);
    end
    checks++;
  endtask

  task automatic test_loop();
    int d0;
    d0 = done_cnt;
    length = 5'd3; loop_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    run_entry(0);
    for (int k = 1; k <= 7; k++) begin
      ovf = 1'b1;
      step();
      ovf = 1'b0;
      step();
      run_entry(k % 3);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    if (busy !== 1'b0 || done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL loop_end: got busy=%b done pulses=%0d, want busy=0 pulses=0", busy, done_cnt - d0);
    end
    checks++;
    step();
  endtask

  task automatic test_pending_overrun();
`ifndef TIM_SEQ_CLR_OVF_EN
    length = 5'd3; loop_en = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      if (j == 1 && (bus_if.w_enable !== 1'b1 || index !== 4'd0)) begin
        errors++; $display("FAIL pend_c1: got en=%b idx=%0d, want en=1 idx=0", bus_if.w_enable, index);
      end
      if (j == 3 && (bus_if.w_enable !== 1'b0 || busy !== 1'b1)) begin
        errors++; $display("FAIL pend_wait: got en=%b busy=%b, want en=0 busy=1", bus_if.w_enable, busy);
      end
      if (j == 4 && (bus_if.w_enable !== 1'b1 || bus_if.w_addr !== 32'd4 || bus_if.w_data !== 32'h2 || index !== 4'd1)) begin
        errors++; $display("FAIL pend_issue: got en=%b addr=%0d data=%h idx=%0d, want en=1 addr=4 data=2 idx=1",
                           bus_if.w_enable, bus_if.w_addr, bus_if.w_data, index);
      end
      if (j == 7 && (bus_if.w_data !== 32'h6 || index !== 4'd2 || overrun !== 1'b0)) begin
        errors++; $display("FAIL pend_c7: got data=%h idx=%0d ovr=%b, want data=6 idx=2 ovr=0", bus_if.w_data, index, overrun);
      end
      if (j == 9 && (overrun !== 1'b1 || done !== 1'b1)) begin
        errors++; $display("FAIL overrun_set: got ovr=%b done=%b, want ovr=1 done=1", overrun, done);
      end
      if (j == 10 && (busy !== 1'b0 || overrun !== 1'b1)) begin
        errors++; $display("FAIL overrun_hold: got busy=%b ovr=%b, want busy=0 ovr=1", busy, overrun);
      end
      if (j == 1 || j == 3 || j == 4 || j == 7 || j == 9 || j == 10) checks++;
      start = (j == 0);
      ovf = ((j % 2) == 1) && (j <= 7);
      step();
    end
    ovf = 1'b0;
    start = 1'b1; length = 5'd3;
    step();
    start = 1'b0;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_clear: got ovr=%b after start, want 0", overrun);
    end
    checks++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
`endif
  endtask

  task automatic test_stop_and_bad_start();
    int d0;
    d0 = done_cnt;
    length = 5'd3; loop_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    if (bus_if.w_enable !== 1'b1 || bus_if.w_addr !== 32'd4) begin
      errors++; $display("FAIL stop_wrlo: got en=%b addr=%0d, want en=1 addr=4", bus_if.w_enable, bus_if.w_addr);
    end
    checks++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    if (bus_if.w_enable !== 1'b0 || busy !== 1'b0 || bus_if.w_addr !== 32'd4 || bus_if.w_data !== 32'h1) begin
      errors++; $display("FAIL stop_idle: got en=%b busy=%b addr=%0d data=%h, want en=0 busy=0 addr=4 data=1",
                         bus_if.w_enable, busy, bus_if.w_addr, bus_if.w_data);
    end
    checks++;
    step();
    if (bus_if.w_enable !== 1'b0 || done_cnt - d0 !== 0) begin
      errors++; $display("FAIL stop_nohi: got en=%b done pulses=%0d, want en=0 pulses=0", bus_if.w_enable, done_cnt - d0);
    end
    checks++;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    if (busy !== 1'b0 || bus_if.w_enable !== 1'b0) begin
      errors++; $display("FAIL start_stop: got busy=%b en=%b, want 0 0", busy, bus_if.w_enable);
    end
    checks++;
    length = 5'd0; start = 1'b1;
    step();
    if (busy !== 1'b0 || bus_if.w_enable !== 1'b0) begin
      errors++; $display("FAIL len0: got busy=%b en=%b, want 0 0", busy, bus_if.w_enable);
    end
    checks++;
    length = 5'd17;
    step();
    if (busy !== 1'b0 || bus_if.w_enable !== 1'b0) begin
      errors++; $display("FAIL len17: got busy=%b en=%b, want 0 0", busy, bus_if.w_enable);
    end
    checks++;
    length = 5'd16;
    step();
    start = 1'b0;
    if (busy !== 1'b1 || bus_if.w_enable !== 1'b1) begin
      errors++; $display("FAIL len16: got busy=%b en=%b, want 1 1", busy, bus_if.w_enable);
    end
    checks++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic test_err();
    bus_if.err = 1'b1;
    step();
    bus_if.err = 1'b0;
    if (err_flag !== 1'b0) begin
      errors++; $display("FAIL err_idle: got err=%b with no write, want 0", err_flag);
    end
    checks++;
    length = 5'd3; loop_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    bus_if.err = 1'b1;
    step();
    bus_if.err = 1'b0;
    if (err_flag !== 1'b1) begin
      errors++; $display("FAIL err_set: got err=%b after WR_HI error, want 1", err_flag);
    end
    checks++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(); step();
    if (err_flag !== 1'b1) begin
      errors++; $display("FAIL err_hold: got err=%b while idle, want 1", err_flag);
    end
    checks++;
    start = 1'b1;
    step();
    start = 1'b0;
    if (err_flag !== 1'b0) begin
      errors++; $display("FAIL err_clear: got err=%b after start, want 0", err_flag);
    end
    checks++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    load_table();
    test_single_run();
    test_loop();
    test_pending_overrun();
    test_stop_and_bad_start();
    test_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_pwm_sequencer.md
# timer_pwm_sequencer

Bus master that sequences the timer peripheral's four PWM channels through a table of duty-cycle words, one table entry per timer period. It sits between the SoC host and the timer slave's write port, which it drives directly. On each timer overflow it writes the next entry into the timer's pulse registers, then loops or stops at the end of the programmed length. Host software loads the table and starts the sequencer; no CPU involvement per period.

## Interface
- DEPTH, 16: table entries (power of two, 2..256)
- IDX_W, 4: log2(DEPTH)
- i_Clk  in  1  clock
- i_Rst  in  1  reset i_Rst, synchronous, active-high; clock i_Clk
- i_CfgWe  in  1  table write strobe
- i_CfgAddr  in  IDX_W  table entry index
- i_CfgData  in  32  entry: [15:0] = {ch2,ch1}, [31:16] = {ch4,ch3}
- i_Start  in  1  start pulse (ignored unless IDLE)
- i_Stop  in  1  abort pulse
- i_Length  in  IDX_W+1  entries to play (1..DEPTH), sampled at start
- i_Loop  in  1  wrap to entry 0 after last, sampled at start
- i_TimerOverflow  in  1  timer overflow output (level, synchronous to i_Clk)
- i_Err  in  1  timer slave error, valid the cycle after a write
- o_WEnable  out  1  timer write strobe
- o_WAddr  out  32  timer register address
- o_WData  out  32  timer write data
- o_Busy  out  1  high in any state but IDLE
- o_Index  out  IDX_W  entry currently applied
- o_Done  out  1  one-cycle pulse at end of non-looping run
- o_ErrFlag  out  1  sticky: i_Err seen after a sequencer write
- o_Overrun  out  1  sticky: overflow edge lost while one was pending

## Operation
- Table: DEPTH x 32 registers, written any time via i_CfgWe; a write to the entry currently being applied takes effect on its next visit.
- States: IDLE, WR_LO, WR_HI, [WR_CLR], WAIT_OVF.
- IDLE: i_Start with 1 <= i_Length <= DEPTH latches length/loop, index=0, -> WR_LO. i_Length of 0 or >DEPTH: start ignored, stays IDLE.
- WR_LO: o_WEnable=1, o_WAddr=4, o_WData={16'b0, entry[15:0]} -> WR_HI.
- WR_HI: o_WEnable=1, o_WAddr=5, o_WData={16'b0, entry[31:16]} -> WR_CLR (macro) or WAIT_OVF.
- WAIT_OVF: on overflow edge (or pending flag): if index == length-1 and !loop -> o_Done pulse, IDLE; else index = (index == length-1) ? 0 : index+1, -> WR_LO.
- Overflow edge: i_TimerOverflow registered once; edge = current & ~previous. An edge arriving outside WAIT_OVF sets pending; a second edge while pending already set sets o_Overrun, pending stays 1.
- i_Stop: highest priority, any state -> IDLE next cycle, pending cleared, no further writes; a write driven in the stop cycle still completes. No o_Done.
- o_ErrFlag: set when i_Err=1 in the cycle after o_WEnable=1; cleared only by reset or i_Start. o_Overrun: likewise.
- o_WEnable is 0 in IDLE and WAIT_OVF; o_WAddr/o_WData hold last value when idle.

## Timing
- Reset: all outputs 0, state IDLE, index 0, pending 0; table contents undefined.
- i_Start at cycle t -> WR_LO write at t+1, WR_HI write at t+2, (WR_CLR at t+3).
- Overflow level rises at cycle c -> edge detected at c+1 -> WR_LO write at c+2.
- o_Done asserted the cycle the terminating edge is consumed; o_Busy falls the next cycle.
- o_Index updates in the same cycle the state enters WR_LO.
- Start in the same cycle as Stop: Stop wins.

## Configuration
- TIM_SEQ_CLR_OVF_EN defined: WR_CLR state present; after WR_HI writes o_WAddr=2, o_WData=0 (clears the timer's overflow status), then WAIT_OVF. Three writes per entry.
- Undefined: WR_CLR absent; WR_HI -> WAIT_OVF; two writes per entry.

## Test plan
- Load entries 0..2 = 32'h0003_0001, 32'h0004_0002, 32'h0005_0006; length 3, loop 0; start -> writes (4,0x0001),(5,0x0003) at t+1/t+2; after 3 overflows o_Done pulses once, o_Busy=0.
- Same table, loop 1; 7 overflows -> o_Index sequence 0,1,2,0,1,2,0,1, no o_Done.
- Overflow edge during WR_HI -> pending, WR_LO issued immediately after WAIT_OVF entry; two edges during writes -> o_Overrun=1.
- i_Stop during WR_LO -> WR_LO write completes, no WR_HI, IDLE next cycle; i_Length=0 start -> stays IDLE, no writes.
- i_Err=1 the cycle after WR_HI -> o_ErrFlag=1, held until next i_Start.
- With TIM_SEQ_CLR_OVF_EN: third write (2,0x0) at t+3; without: WAIT_OVF at t+3, no third write.
